// File: rtl/vram_dma.sv
// vram_dma: block fill/copy engine and bus arbiter between the AVR data bus and RAM port X.
// The CPU always wins the RAM port; the DMA only uses cycles with neither cpu_we nor cpu_read.
`timescale 1ns/1ps
module vram_dma #(
    parameter logic [15:0] BASE = 16'h0050,
    parameter int unsigned AW   = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_data_o,
    input  logic          cpu_we,
    input  logic          cpu_read,
    output logic [7:0]    cpu_data_i,
    output logic [AW-1:0] mem_ax,
    output logic [7:0]    mem_dx,
    output logic          mem_wx,
    input  logic [7:0]    mem_qx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_LAT, S_WR} state_t;

    state_t        r_state;
    logic [AW-1:0] r_src, r_dst, r_len;
    logic [7:0]    r_fill;
    logic          r_mode;
    logic [AW-1:0] r_cur_src, r_cur_dst, r_cur_len;
    logic [7:0]    r_data_q;
    logic          r_busy, r_done;
    logic          r_rd_valid, r_rd_hit;
    logic [7:0]    r_rd_val;

    logic          w_hit, w_free, w_reg_wr, w_start;
    logic [7:0]    w_reg_val;

    assign w_hit    = (cpu_address[15:3] == BASE[15:3]);
    assign w_free   = ~(cpu_we | cpu_read);
    assign w_reg_wr = cpu_we & w_hit;
    assign w_start  = w_reg_wr & (cpu_address[2:0] == 3'd7) & cpu_data_o[0]
                      & (r_state == S_IDLE) & (r_len != '0);

    assign busy = r_busy;
    assign done = r_done;

    always_comb begin
        w_reg_val = '0;
        case (cpu_address[2:0])
            3'd0: w_reg_val = r_src[7:0];
            3'd1: w_reg_val = r_src[15:8];
            3'd2: w_reg_val = r_dst[7:0];
            3'd3: w_reg_val = r_dst[15:8];
            3'd4: w_reg_val = r_len[7:0];
            3'd5: w_reg_val = r_len[15:8];
            3'd6: w_reg_val = r_fill;
            default: w_reg_val = {r_busy, 5'b0, r_mode, 1'b0};
        endcase
    end

    // Read data is zero outside the cycle following a CPU read so reset drives it low.
    always_comb begin
        cpu_data_i = '0;
        if (r_rd_valid)
            cpu_data_i = r_rd_hit ? r_rd_val : mem_qx;
    end

    always_comb begin
        mem_ax = cpu_address;
        mem_dx = cpu_data_o;
        mem_wx = cpu_we & ~w_hit;
        if (w_free) begin
            case (r_state)
                S_RD: mem_ax = r_cur_src;
                S_WR: begin
                    mem_ax = r_cur_dst;
                    mem_dx = r_mode ? r_fill : r_data_q;
                    mem_wx = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_fill     <= '0;
            r_mode     <= 1'b0;
            r_cur_src  <= '0;
            r_cur_dst  <= '0;
            r_cur_len  <= '0;
            r_data_q   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_val   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= cpu_read;
            if (cpu_read) begin
                r_rd_hit <= w_hit;
                r_rd_val <= w_reg_val;
            end

            if (w_reg_wr) begin
                case (cpu_address[2:0])
                    3'd0: r_src[7:0]  <= cpu_data_o;
                    3'd1: r_src[15:8] <= cpu_data_o;
                    3'd2: r_dst[7:0]  <= cpu_data_o;
                    3'd3: r_dst[15:8] <= cpu_data_o;
                    3'd4: r_len[7:0]  <= cpu_data_o;
                    3'd5: r_len[15:8] <= cpu_data_o;
                    3'd6: r_fill      <= cpu_data_o;
                    default: if (r_state == S_IDLE) r_mode <= cpu_data_o[1];
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cur_src <= r_src;
                        r_cur_dst <= r_dst;
                        r_cur_len <= r_len;
                        r_busy    <= 1'b1;
                        r_state   <= cpu_data_o[1] ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    if (w_free)
                        r_state <= S_LAT;
                end
                S_LAT: begin
                    r_data_q <= mem_qx;
                    r_state  <= S_WR;
                end
                S_WR: begin
                    if (w_free) begin
                        r_cur_src <= r_cur_src + 1'b1;
                        r_cur_dst <= r_cur_dst + 1'b1;
                        r_cur_len <= r_cur_len - 1'b1;
                        if (r_cur_len == AW'(1)) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= r_mode ? S_WR : S_RD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_dma.sv
// Scoreboard bench for vram_dma: CPU reads queue their expected byte, a monitor compares on return.
`timescale 1ns/1ps
module tb_vram_dma;
    localparam logic [15:0] BASE = 16'h0050;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_data_o = '0;
    logic        cpu_we = 1'b0, cpu_read = 1'b0;
    logic [7:0]  cpu_data_i;
    logic [15:0] mem_ax;
    logic [7:0]  mem_dx;
    logic        mem_wx;
    logic [7:0]  mem_qx = '0;
    logic        busy, done;

    logic [7:0]  ram [0:65535];
    int          total = 0, bad = 0;
    int          done_cnt = 0, dma_wr_cnt = 0;
    logic        rd_pend = 1'b0;
    logic [7:0]  q_exp[$];
    string       q_name[$];

    vram_dma #(.BASE(BASE), .AW(16)) dut (
        .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address),
        .cpu_data_o(cpu_data_o), .cpu_we(cpu_we), .cpu_read(cpu_read),
        .cpu_data_i(cpu_data_i), .mem_ax(mem_ax), .mem_dx(mem_dx),
        .mem_wx(mem_wx), .mem_qx(mem_qx), .busy(busy), .done(done)
    );

    always #20 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM port X model: synchronous write, registered read
    always @(posedge clock) begin
        if (mem_wx) ram[mem_ax] <= mem_dx;
        mem_qx <= ram[mem_ax];
        if (mem_wx && !cpu_we) dma_wr_cnt++;
    end

    always @(posedge clock or negedge reset_n)
        if (!reset_n) rd_pend <= 1'b0;
        else          rd_pend <= cpu_read;

    always @(negedge clock) begin
        if (rd_pend) begin
            if (q_exp.size() == 0) chk("sb_underflow", 1, 0);
            else chk(q_name.pop_front(), cpu_data_i, q_exp.pop_front());
        end
        if (done) done_cnt++;
        if (cpu_we || cpu_read) begin
            chk("bus_ax", mem_ax, cpu_address);
            chk("bus_wx", mem_wx, cpu_we && (cpu_address[15:3] != BASE[15:3]));
            if (cpu_we) chk("bus_dx", mem_dx, cpu_data_o);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_address = a; cpu_data_o = d; cpu_we = 1'b1;
        @(posedge clock); #1;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_rd(input string n, input logic [15:0] a, input logic [7:0] e);
        q_name.push_back(n); q_exp.push_back(e);
        cpu_address = a; cpu_read = 1'b1;
        @(posedge clock); #1;
        cpu_read = 1'b0;
    endtask

    task automatic wr16(input logic [2:0] off, input logic [15:0] v);
        cpu_wr(BASE + 16'(off), v[7:0]);
        cpu_wr(BASE + 16'(off) + 16'd1, v[15:8]);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin @(posedge clock); #1; n++; end
        chk(name, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, nw, last;
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h0054] = 8'h99;
        ram[16'h0200] = 8'h77;
        ram[16'hFFA0] = 8'h55;
        ram[16'h0002] = 8'h11;
        for (int i = 0; i < 32; i++) ram[16'h2000 + i] = 8'(8'h40 + i);

        // reset state and combinational bus mux under reset
        idle(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_data_i", cpu_data_i, 0);
        cpu_address = 16'h1234; cpu_data_o = 8'h5A; cpu_we = 1'b1; #1;
        chk("rst_mem_ax", mem_ax, 16'h1234);
        chk("rst_mem_dx", mem_dx, 8'h5A);
        chk("rst_mem_wx", mem_wx, 1);
        cpu_address = BASE + 16'd3; #1;
        chk("rst_mem_wx_hit", mem_wx, 0);
        cpu_we = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(2);

        // register readback
        cpu_wr(BASE + 16'd4, 8'h34);
        cpu_rd("len_lo_rb", BASE + 16'd4, 8'h34);
        cpu_rd("ram_rd", 16'h0200, 8'h77);
        cpu_rd("ctrl_idle_rb", BASE + 16'd7, 8'h00);
        chk("win_ram_untouched", ram[16'h0054], 8'h99);

        // LEN=0 start is ignored
        cpu_wr(BASE + 16'd4, 8'h00);
        d = done_cnt;
        cpu_wr(BASE + 16'd7, 8'h01);
        idle(3);
        chk("len0_busy", busy, 0);
        chk("len0_done", done_cnt - d, 0);

        // fill F000h..FF9Fh with 20h, idle CPU
        wr16(0, 16'h0000); wr16(2, 16'hF000); wr16(4, 16'h0FA0);
        cpu_wr(BASE + 16'd6, 8'h20);
        d = done_cnt;
        cpu_wr(BASE + 16'd7, 8'h03);
        n = 0;
        while (busy && n < 10000) begin @(posedge clock); #1; n++; end
        chk("fill_busy_cycles", n, 4000);
        idle(2);
        chk("fill_done_pulses", done_cnt - d, 1);
        nw = 0;
        for (int a = 16'hF000; a <= 16'hFF9F; a++) if (ram[a] !== 8'h20) nw++;
        chk("fill_range", nw, 0);
        cpu_rd("fill_last", 16'hFF9F, 8'h20);
        cpu_rd("fill_past_end", 16'hFFA0, 8'h55);

        // copy with CPU writing every other cycle
        for (int i = 0; i < 16; i++) ram[16'hF050 + i] = 8'(i);
        wr16(0, 16'hF050); wr16(2, 16'hF000); wr16(4, 16'h0010);
        d = done_cnt;
        cpu_wr(BASE + 16'd7, 8'h01);
        cpu_rd("ctrl_busy_rb", BASE + 16'd7, 8'h80);
        last = 0; n = 0;
        while (busy && n < 200) begin
            cpu_wr(16'h0100, 8'(n + 8'h60)); last = n + 8'h60;
            idle(1); n++;
        end
        chk("copy_finished", busy, 0);
        idle(1);
        chk("copy_done_pulses", done_cnt - d, 1);
        cpu_rd("cpu_wr_landed", 16'h0100, 8'(last));
        nw = 0;
        for (int i = 0; i < 16; i++) if (ram[16'hF000 + i] !== 8'(i)) nw++;
        chk("copy_range", nw, 0);
        cpu_rd("copy_no_overrun", 16'hF010, 8'h20);

        // start and register writes while busy do not disturb the transfer
        wr16(0, 16'hF050); wr16(2, 16'hF100); wr16(4, 16'h0008);
        cpu_wr(BASE + 16'd7, 8'h01);
        cpu_wr(BASE + 16'd0, 8'h00);
        cpu_wr(BASE + 16'd7, 8'h03);
        cpu_wr(BASE + 16'd2, 8'h80);
        wait_idle("busy_restart_finished", 200);
        nw = 0;
        for (int i = 0; i < 8; i++) if (ram[16'hF100 + i] !== 8'(i)) nw++;
        chk("busy_restart_range", nw, 0);
        cpu_rd("busy_restart_no_overrun", 16'hF108, 8'h20);
        cpu_rd("src_reg_updated", BASE + 16'd0, 8'h00);
        cpu_rd("mode_kept", BASE + 16'd7, 8'h00);

        // fill wrapping past FFFFh
        wr16(2, 16'hFFFE); wr16(4, 16'h0004);
        cpu_wr(BASE + 16'd6, 8'hAA);
        cpu_wr(BASE + 16'd7, 8'h03);
        wait_idle("wrap_finished", 50);
        cpu_rd("wrap_fffe", 16'hFFFE, 8'hAA);
        cpu_rd("wrap_ffff", 16'hFFFF, 8'hAA);
        cpu_rd("wrap_0000", 16'h0000, 8'hAA);
        cpu_rd("wrap_0001", 16'h0001, 8'hAA);
        cpu_rd("wrap_0002", 16'h0002, 8'h11);
        cpu_rd("wrap_fffd", 16'hFFFD, 8'h00);

        // reset after 5 bytes of a 32-byte copy
        wr16(0, 16'h2000); wr16(2, 16'h3000); wr16(4, 16'h0020);
        d = dma_wr_cnt;
        cpu_wr(BASE + 16'd7, 8'h01);
        n = 0;
        while (dma_wr_cnt < d + 5 && n < 500) begin @(posedge clock); #1; n++; end
        chk("midrst_bytes_before", dma_wr_cnt - d, 5);
        reset_n = 1'b0; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cpu_data_i", cpu_data_i, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) cpu_rd("midrst_reg_zero", BASE + 16'(i), 8'h00);
        nw = 0;
        for (int i = 0; i < 32; i++)
            if (ram[16'h3000 + i] !== ((i < 5) ? 8'(8'h40 + i) : 8'h00)) nw++;
        chk("midrst_dst_bytes", nw, 0);

        wr16(0, 16'h2000); wr16(2, 16'h3100); wr16(4, 16'h0004);
        d = done_cnt;
        cpu_wr(BASE + 16'd7, 8'h01);
        wait_idle("post_rst_finished", 50);
        idle(1);
        chk("post_rst_done", done_cnt - d, 1);
        nw = 0;
        for (int i = 0; i < 4; i++) if (ram[16'h3100 + i] !== 8'(8'h40 + i)) nw++;
        chk("post_rst_copy", nw, 0);

        idle(2);
        chk("sb_drained", q_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
